// File: rtl/rsa_pkg.sv
// Definitions shared by the RSA datapath blocks (multiply-add and divider).
// The FSM state encoding and the default operand width live here.
package rsa_pkg;

  localparam int DEFAULT_WIDTH = 512;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/shiftadd_muladd_step.sv
// One radix-2 shift-add iteration: conditionally add the multiplicand into the
// high half, then shift {carry, hi, lo} right by one place.
module muladd_step #(
  parameter int WIDTH = 512
) (
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] mcand_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] addend;
  logic [WIDTH:0] sum;

  // Conditional add and right shift of the partial product.
  always_comb begin
    addend = {(WIDTH+1){1'b0}};
    if (lo_i[0]) begin
      addend = {1'b0, mcand_i};
    end else begin
      addend = {(WIDTH+1){1'b0}};
    end
    // The extra sum bit carries the intermediate overflow into hi's MSB.
    sum  = {1'b0, hi_i} + addend;
    hi_o = sum[WIDTH:1];
    lo_o = {sum[0], lo_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/shiftadd_muladd.sv
// Sequential shift-add multiply-accumulate, P = X*Y + Z, one bit of Y per
// cycle, using the same start/busy/done handshake as the divider.
module shiftadd_muladd
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     X,
  input  logic [WIDTH-1:0]     Y,
  input  logic [WIDTH-1:0]     Z,
  output logic [2*WIDTH-1:0]   P,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     hi_step;
  logic [WIDTH-1:0]     lo_step;

  muladd_step #(.WIDTH(WIDTH)) u_step (
    .hi_i    (hi_q),
    .lo_i    (lo_q),
    .mcand_i (mcand_q),
    .hi_o    (hi_step),
    .lo_o    (lo_step)
  );

  // Next-state logic for the FSM, counter and datapath registers.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Z preloads hi so that WIDTH right shifts bring it to weight 2^0.
          mcand_d = X;
          hi_d    = Z;
          lo_d    = Y;
          cnt_d   = {CNT_W{1'b0}};
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        hi_d = hi_step;
        lo_d = lo_step;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          p_d     = {hi_step, lo_step};
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_RUN;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mcand_q <= {WIDTH{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      p_q     <= {(2*WIDTH){1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign P    = p_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
